car_alarm_ctrl: RTL

- Parametrised, clocked car door alarm controller; replaces the fixed 5-door combinational decoder with arm/disarm control.
- Latches per-door open events and runs an arm/entry-delay/siren state machine with cycle-count timers.
- Drives a 7-segment code for the lowest-index open door.
- Sits between door sensors/close buttons on the board and the siren and display drivers.

---
 rtl/car_alarm_pkg.sv | 40 ++++
 rtl/car_alarm_ctrl_if.sv | 38 +++
 rtl/car_alarm_ctrl_alarm_timer.sv | 46 ++++
 rtl/car_alarm_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/car_alarm_pkg.sv
// -----------------------------------------------------------------------------
// car_alarm_pkg
// Shared definitions for the car door alarm controller:
//   - state_t      : FSM state encoding (ST_DISARMED .. ST_ALARM), also driven
//                    onto the 2-bit state output
//   - SEG_*        : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - door_seg()   : maps a door index to the code shown for that door
// -----------------------------------------------------------------------------
package car_alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ENTRY    = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Doors 5..7 have no letter of their own and share the dash.
    function automatic logic [6:0] door_seg(input logic [2:0] idx);
        logic [6:0] code;
        case (idx)
            3'd0:    code = SEG_F;
            3'd1:    code = SEG_B;
            3'd2:    code = SEG_E;
            3'd3:    code = SEG_C;
            3'd4:    code = SEG_D;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/car_alarm_ctrl_if.sv
// -----------------------------------------------------------------------------
// car_alarm_ctrl_if
// Board-side signal bundle of the alarm controller.
//   master : sensor/button side (drives arm, disarm, door_open, door_close_btn)
//   slave  : the controller (drives door_latched, siren, state, arm_err, segment)
// Signals:
//   arm, disarm        single-cycle requests
//   door_open          level sensors, one bit per door
//   door_close_btn     single-cycle close acknowledge per door
//   door_latched       registered latched-open status
//   siren              registered siren drive
//   state              FSM state (0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM)
//   arm_err            one-cycle pulse on a rejected arm request
//   segment            active-low 7-segment code {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
interface car_alarm_ctrl_if #(
    parameter int NUM_DOORS = 5
);
    logic                 arm;
    logic                 disarm;
    logic [NUM_DOORS-1:0] door_open;
    logic [NUM_DOORS-1:0] door_close_btn;
    logic [NUM_DOORS-1:0] door_latched;
    logic                 siren;
    logic [1:0]           state;
    logic                 arm_err;
    logic [6:0]           segment;

    modport master (
        output arm, disarm, door_open, door_close_btn,
        input  door_latched, siren, state, arm_err, segment
    );

    modport slave (
        input  arm, disarm, door_open, door_close_btn,
        output door_latched, siren, state, arm_err, segment
    );
endinterface

// File: rtl/car_alarm_ctrl_alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
// Loadable, saturating down-counter shared by the ENTRY and ALARM phases.
// Ports:
//   clk, rst_n   clock / async active-low reset (count clears to 0)
//   load_i       load load_val_i this cycle (wins over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one, stopping at 0
//   done_o       high during the last cycle of a loaded interval
// -----------------------------------------------------------------------------
module alarm_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of N lasts N cycles: the FSM acts on the edge ending the cycle
    // in which the count reads 1 (or 0 if it has already saturated).
    assign done_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/car_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// car_alarm_ctrl
// Clocked car door alarm: per-door open latches, an arm / entry-delay / siren
// state machine timed by a shared alarm_timer, and a 7-segment code for the
// lowest-index latched door.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     car_alarm_ctrl_if.slave (requests and sensors in, status out)
// Build option:
//   CAR_ALARM_CHIRP_EN  when defined, the siren gives a 2-cycle chirp on every
//                       accepted arm and every disarm that leaves a non-DISARMED
//                       state; entry to ALARM cancels a running chirp.
// -----------------------------------------------------------------------------
module car_alarm_ctrl
    import car_alarm_pkg::*;
#(
    parameter int NUM_DOORS  = 5,
    parameter int ENTRY_DLY  = 16,
    parameter int SIREN_TIME = 64,
    parameter int CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    car_alarm_ctrl_if.slave bus
);
    state_t               state_q, state_d;
    logic [NUM_DOORS-1:0] latched_q, latched_d;
    logic                 siren_q, siren_d;
    logic                 arm_err_q, arm_err_d;
    logic [6:0]           seg_q, seg_d;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_dec;
    logic                 tmr_done;

    // ---------------- door latches -------------------------------------------
    // A door that is still open keeps its latch set regardless of the button.
    for (genvar g = 0; g < NUM_DOORS; g++) begin : g_latch
        assign latched_d[g] = bus.door_open[g] | (latched_q[g] & ~bus.door_close_btn[g]);
    end

    // ---------------- segment code of lowest latched door --------------------
    always_comb begin
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = 3'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_DOORS - 1; i >= 0; i--) begin
            if (latched_q[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
        seg_d = found ? door_seg(idx) : SEG_BLANK;
    end

    // ---------------- FSM next state ------------------------------------------
    // NOTE: every signal written here is given a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        arm_err_d = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                // disarm in the same cycle suppresses the arm request entirely
                if (bus.arm && !bus.disarm) begin
                    if (latched_q == '0) state_d   = ST_ARMED;
                    else                 arm_err_d = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.disarm) begin
                    state_d = ST_DISARMED;
                end else if (|latched_q) begin
                    state_d  = ST_ENTRY;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(ENTRY_DLY);
                end
            end
            ST_ENTRY: begin
                if (bus.disarm) begin
                    state_d = ST_DISARMED;
                end else if (tmr_done) begin
                    state_d  = ST_ALARM;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SIREN_TIME);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ALARM: begin
                if (bus.disarm) begin
                    state_d = ST_DISARMED;
                end else begin
                    tmr_dec = 1'b1;
                    if (tmr_done) state_d = ST_ARMED;
                end
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // ---------------- siren ---------------------------------------------------
`ifdef CAR_ALARM_CHIRP_EN
    logic [1:0] chirp_q, chirp_d;
    logic       chirp_start;

    assign chirp_start = (state_q == ST_DISARMED && state_d == ST_ARMED) ||
                         (bus.disarm && state_q != ST_DISARMED);

    always_comb begin
        chirp_d = chirp_q;
        if (state_d == ST_ALARM)  chirp_d = 2'd0;
        else if (chirp_start)     chirp_d = 2'd2;
        else if (chirp_q != 2'd0) chirp_d = chirp_q - 2'd1;
        siren_d = (state_d == ST_ALARM) || (chirp_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chirp_q <= 2'd0;
        else        chirp_q <= chirp_d;
    end
`else
    assign siren_d = (state_d == ST_ALARM);
`endif

    // ---------------- shared timer --------------------------------------------
    alarm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    // ---------------- registers -----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DISARMED;
            latched_q <= '0;
            siren_q   <= 1'b0;
            arm_err_q <= 1'b0;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            siren_q   <= siren_d;
            arm_err_q <= arm_err_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.door_latched = latched_q;
    assign bus.siren        = siren_q;
    assign bus.state        = state_q;
    assign bus.arm_err      = arm_err_q;
    assign bus.segment      = seg_q;

endmodule
